env_console: RTL and testbench
==============================

# env_console

Port-mapped serial console device for the tv80 test environment, sharing the CPU I/O bus (`iorq_n`/`rd_n`/`wr_n`/`addr`/`DO`/`DI`) alongside the existing environment I/O device. It accepts characters written by the CPU into a TX FIFO and serializes them 8N1 on `txd`. It deserializes `rxd` (or `txd` in loopback) into an RX FIFO the CPU can read. Status, error and interrupt reporting let test programs exercise polled and interrupt-driven console code.

## Interface
- `BASE_ADDR`, 8'hA0: I/O base; device decodes `BASE_ADDR`..`BASE_ADDR+3`.
- `FIFO_AW`, 4: log2 FIFO depth; each FIFO holds 16 entries.

- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `iorq_n`  in  1  CPU I/O request, active low.
- `rd_n`  in  1  CPU read strobe, active low.
- `wr_n`  in  1  CPU write strobe, active low.
- `addr`  in  8  I/O port address.
- `DO`  in  8  CPU write data.
- `DI`  inout  8  CPU read data; driven only during a decoded read, else 8'hzz.
- `rxd`  in  1  serial input, idle high; asynchronous to `clk`.
- `txd`  out  1  serial output, idle high.
- `irq_n`  out  1  interrupt, active low.

## Operation
- Registers, offset from `BASE_ADDR`:
  - +0 DATA. Write pushes TX FIFO; if full, byte dropped and TXOVF set. Read returns RX head, or 8'h00 when empty (no pop, no error).
  - +1 STATUS, read: b0 tx_empty, b1 tx_full, b2 rx_avail, b3 rx_full, b4 tx_busy, b5 TXOVF, b6 RXOVF, b7 FERR. Write: 1 clears the matching sticky bit in b5-b7 (W1C); other bits ignored.
  - +2 DIV, R/W, reset 8'd3. Bit period = max(DIV,1)+1 clocks.
  - +3 CTRL, R/W, reset 8'h02. b0 loopback (RX input = `txd`), b1 tx_enable, b2 rx_irq_en; b7-b3 read 0.
- Access detect: `wr_act = !iorq_n & !wr_n & addr hit`, registered once.
  - Write side effects occur only on the first cycle `wr_act` is high (rising-edge detect), however long the CPU holds the strobe.
  - RX pop occurs on the cycle after the decoded read strobe deasserts, so `DI` is stable for the whole access.
- TX FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP. Each non-IDLE state lasts one bit period.
  - IDLE pops the FIFO when it is non-empty and tx_enable=1.
  - At the end of STOP, goes directly to START if the FIFO is non-empty and tx_enable=1; otherwise goes to IDLE.
  - Clearing tx_enable mid-frame finishes the current frame.
- RX path: two-flop synchronizer on the selected input. RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE detects a low level. START waits (period>>1) clocks, then rechecks: if high, glitch, return to IDLE.
  - DATA samples every full period, LSB first. STOP samples once.
  - If the stop bit is 0, set FERR; the byte is still pushed.
  - Push to a full RX FIFO drops the byte and sets RXOVF.
- `irq_n` = !(rx_irq_en & rx_avail), registered.
- FIFOs: simultaneous push and pop allowed at any occupancy. A push to a full FIFO in the same cycle as a pop succeeds.
- DIV write mid-frame takes effect at the next bit boundary.

## Timing
- Reset values: `txd`=1, `irq_n`=1, `DI`=z, both FIFOs empty, STATUS=8'h01, DIV=3, CTRL=8'h02, both FSMs IDLE. Reset is asynchronous mid-frame: `txd` returns to 1 immediately and the partial frame is lost.
- Write to DATA sampled at edge N → FIFO entry at N → `txd` falls at edge N+1 when TX is idle. Frame = 10 bit periods. Back-to-back frames have no idle gap.
- STATUS reflects a push or pop one clock after the edge that performs it.
- RX byte visible (rx_avail=1) 1 clock after the stop-bit sample. The sample point is offset by the 2-clock synchronizer latency.
- `irq_n` asserts 1 clock after rx_avail and deasserts 1 clock after the RX FIFO empties.

## Test plan
- Reset: check `txd`=1, `irq_n`=1, STATUS=0x01, DIV=0x03, CTRL=0x02.
- TX frame: write 8'hA5 to 0xA0 with DIV=3 → `txd` goes 0 for 4 clk, then 1,0,1,0,0,1,0,1 (4 clk each), then stop 1 → tx_busy clears, STATUS=0x01.
- Loopback + irq: CTRL=0x07, write 0x3C, 0xC3 → `irq_n` low after the first frame. Reads of 0xA0 return 0x3C then 0xC3; a third read returns 0x00. `irq_n` high after the second pop.
- Overflow: CTRL=0x00, write 17 bytes → tx_full=1, TXOVF=1. Write 0x20 to 0xA1 → TXOVF=0, tx_full stays 1.
- Framing/glitch: drive a 1-clk low pulse on `rxd` → no byte received. Drive a frame with stop bit 0 → byte pushed, FERR=1.
- Long strobe: hold a write to 0xA0 for 5 clk → exactly one FIFO entry is added.

Source files
------------

// File: rtl/env_console_if.sv
// CPU I/O bus strobes, address and write data shared by the tv80 environment devices.
// The read-data return path (DI) stays a tristate port on each device.
interface env_console_if;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] addr;
    logic [7:0] DO;

    modport master (output iorq_n, output rd_n, output wr_n, output addr, output DO);
    modport slave  (input  iorq_n, input  rd_n, input  wr_n, input  addr, input  DO);
endinterface

// File: rtl/env_console.sv
// Port-mapped 8N1 serial console for the tv80 test environment: TX/RX FIFOs,
// DATA/STATUS/DIV/CTRL registers, loopback and an RX-available interrupt.
module env_console #(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter int         FIFO_AW   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    env_console_if.slave  bus,
    inout  wire  [7:0]    DI,
    input  logic          rxd,
    output logic          txd,
    output logic          irq_n
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_t;

    logic [7:0]       off_s;
    logic             hit_s, wr_act_s, rd_act_s, wr_act_r, rd_act_r, wr_pulse_s;
    logic [1:0]       rd_off_r;
    logic             wr_data_s, wr_stat_s, wr_div_s, wr_ctrl_s, rd_pop_req_s;
    logic [7:0]       div_r;
    logic [2:0]       ctrl_r;
    logic             txovf_r, rxovf_r, ferr_r, irq_r;
    logic [7:0]       rd_data_s;
    logic [7:0]       div_eff_s;
    logic [8:0]       bit_len_m1_s, period_s, half_m1_s;

    logic [7:0]       tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wptr_r, tx_rptr_r;
    logic             tx_empty_s, tx_full_s, tx_push_s, tx_pop_s, tx_ovf_set_s;
    logic [7:0]       tx_head_s;
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wptr_r, rx_rptr_r;
    logic             rx_empty_s, rx_full_s, rx_push_s, rx_pop_s, rx_ovf_set_s;
    logic [7:0]       rx_head_s;

    ser_state_t       tx_state_r, tx_next_s;
    logic [8:0]       tx_cnt_r;
    logic [2:0]       tx_bit_r;
    logic [7:0]       tx_sh_r;
    logic             txd_r, txd_nxt_s, tx_end_s, tx_go_s, tx_load_s, tx_reload_s, tx_shift_s;

    ser_state_t       rx_state_r, rx_next_s;
    logic [8:0]       rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_sh_r;
    logic             rx_sel_s, rx_s1_r, rx_s2_r, rx_tick_s;
    logic             rx_half_load_s, rx_full_load_s, rx_sample_s, rx_push_req_s;

    // Bus decode; side effects fire on the first cycle of a write strobe only.
    assign off_s        = bus.addr - BASE_ADDR;
    assign hit_s        = (off_s[7:2] == 6'd0);
    assign wr_act_s     = ~bus.iorq_n & ~bus.wr_n & hit_s;
    assign rd_act_s     = ~bus.iorq_n & ~bus.rd_n & hit_s;
    assign wr_pulse_s   = wr_act_s & ~wr_act_r;
    assign wr_data_s    = wr_pulse_s & (off_s[1:0] == 2'd0);
    assign wr_stat_s    = wr_pulse_s & (off_s[1:0] == 2'd1);
    assign wr_div_s     = wr_pulse_s & (off_s[1:0] == 2'd2);
    assign wr_ctrl_s    = wr_pulse_s & (off_s[1:0] == 2'd3);
    assign rd_pop_req_s = rd_act_r & ~rd_act_s & (rd_off_r == 2'd0);

    // Bit timing: period = max(DIV,1)+1 clocks, counters hold period-1.
    assign div_eff_s    = (div_r == 8'd0) ? 8'd1 : div_r;
    assign bit_len_m1_s = {1'b0, div_eff_s};
    assign period_s     = bit_len_m1_s + 9'd1;
    assign half_m1_s    = (period_s >> 1) - 9'd1;

    // Access strobe history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_act_r <= 1'b0;
            rd_act_r <= 1'b0;
            rd_off_r <= 2'd0;
        end else begin
            wr_act_r <= wr_act_s;
            rd_act_r <= rd_act_s;
            if (rd_act_s) rd_off_r <= off_s[1:0];
        end
    end

    // Configuration, sticky error flags and registered interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r   <= 8'd3;
            ctrl_r  <= 3'b010;
            txovf_r <= 1'b0;
            rxovf_r <= 1'b0;
            ferr_r  <= 1'b0;
            irq_r   <= 1'b1;
        end else begin
            if (wr_div_s)  div_r  <= bus.DO;
            if (wr_ctrl_s) ctrl_r <= bus.DO[2:0];
            txovf_r <= tx_ovf_set_s | (txovf_r & ~(wr_stat_s & bus.DO[5]));
            rxovf_r <= rx_ovf_set_s | (rxovf_r & ~(wr_stat_s & bus.DO[6]));
            ferr_r  <= (rx_push_req_s & ~rx_s2_r) | (ferr_r & ~(wr_stat_s & bus.DO[7]));
            irq_r   <= ~(ctrl_r[2] & ~rx_empty_s);
        end
    end

    // FIFO flags; a push into a full FIFO succeeds when a pop happens in the same cycle.
    assign tx_empty_s   = (tx_wptr_r == tx_rptr_r);
    assign tx_full_s    = (tx_wptr_r[FIFO_AW] != tx_rptr_r[FIFO_AW]) &&
                          (tx_wptr_r[FIFO_AW-1:0] == tx_rptr_r[FIFO_AW-1:0]);
    assign tx_pop_s     = tx_load_s;
    assign tx_push_s    = wr_data_s & (~tx_full_s | tx_pop_s);
    assign tx_ovf_set_s = wr_data_s & tx_full_s & ~tx_pop_s;
    assign tx_head_s    = tx_mem[tx_rptr_r[FIFO_AW-1:0]];
    assign rx_empty_s   = (rx_wptr_r == rx_rptr_r);
    assign rx_full_s    = (rx_wptr_r[FIFO_AW] != rx_rptr_r[FIFO_AW]) &&
                          (rx_wptr_r[FIFO_AW-1:0] == rx_rptr_r[FIFO_AW-1:0]);
    assign rx_pop_s     = rd_pop_req_s & ~rx_empty_s;
    assign rx_push_s    = rx_push_req_s & (~rx_full_s | rx_pop_s);
    assign rx_ovf_set_s = rx_push_req_s & rx_full_s & ~rx_pop_s;
    assign rx_head_s    = rx_mem[rx_rptr_r[FIFO_AW-1:0]];

    // FIFO storage (no reset needed, guarded by pointers).
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem[tx_wptr_r[FIFO_AW-1:0]] <= bus.DO;
        if (rx_push_s) rx_mem[rx_wptr_r[FIFO_AW-1:0]] <= rx_sh_r;
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wptr_r <= '0;
            tx_rptr_r <= '0;
            rx_wptr_r <= '0;
            rx_rptr_r <= '0;
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_ONE;
        end
    end

    assign tx_end_s = (tx_cnt_r == 9'd0);
    assign tx_go_s  = ~tx_empty_s & ctrl_r[1];

    // TX state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tx_state_r <= S_IDLE;
        else          tx_state_r <= tx_next_s;
    end

    // TX next state; frames chain from STOP straight into START.
    always_comb begin
        tx_next_s = tx_state_r;
        case (tx_state_r)
            S_IDLE:  if (tx_go_s) tx_next_s = S_START; else tx_next_s = S_IDLE;
            S_START: if (tx_end_s) tx_next_s = S_DATA; else tx_next_s = S_START;
            S_DATA:  if (tx_end_s && (tx_bit_r == 3'd7)) tx_next_s = S_STOP; else tx_next_s = S_DATA;
            S_STOP: begin
                if (tx_end_s) begin
                    if (tx_go_s) tx_next_s = S_START; else tx_next_s = S_IDLE;
                end else begin
                    tx_next_s = S_STOP;
                end
            end
            default: tx_next_s = S_IDLE;
        endcase
    end

    // TX outputs: FIFO pop, bit-timer reload, shift and next line level.
    always_comb begin
        tx_load_s   = (tx_next_s == S_START) && (tx_state_r != S_START);
        tx_reload_s = tx_load_s | ((tx_state_r != S_IDLE) & tx_end_s);
        tx_shift_s  = (tx_state_r == S_DATA) & tx_end_s;
        case (tx_next_s)
            S_START: txd_nxt_s = 1'b0;
            S_DATA:  if (tx_shift_s) txd_nxt_s = tx_sh_r[1]; else txd_nxt_s = tx_sh_r[0];
            default: txd_nxt_s = 1'b1;
        endcase
    end

    // TX datapath; DIV is sampled only when a new bit begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_cnt_r <= 9'd0;
            tx_bit_r <= 3'd0;
            tx_sh_r  <= 8'd0;
            txd_r    <= 1'b1;
        end else begin
            if (tx_reload_s)            tx_cnt_r <= bit_len_m1_s;
            else if (tx_cnt_r != 9'd0)  tx_cnt_r <= tx_cnt_r - 9'd1;
            if (tx_load_s) begin
                tx_sh_r  <= tx_head_s;
                tx_bit_r <= 3'd0;
            end else if (tx_shift_s) begin
                tx_sh_r  <= {1'b0, tx_sh_r[7:1]};
                tx_bit_r <= tx_bit_r + 3'd1;
            end
            txd_r <= txd_nxt_s;
        end
    end

    assign rx_sel_s  = ctrl_r[0] ? txd_r : rxd;
    assign rx_tick_s = (rx_cnt_r == 9'd0);

    // RX synchronizer and state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_r    <= 1'b1;
            rx_s2_r    <= 1'b1;
            rx_state_r <= S_IDLE;
        end else begin
            rx_s1_r    <= rx_sel_s;
            rx_s2_r    <= rx_s1_r;
            rx_state_r <= rx_next_s;
        end
    end

    // RX next state; a start bit that is high at mid-bit is treated as a glitch.
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            S_IDLE:  if (!rx_s2_r) rx_next_s = S_START; else rx_next_s = S_IDLE;
            S_START: begin
                if (rx_tick_s) begin
                    if (rx_s2_r) rx_next_s = S_IDLE; else rx_next_s = S_DATA;
                end else begin
                    rx_next_s = S_START;
                end
            end
            S_DATA:  if (rx_tick_s && (rx_bit_r == 3'd7)) rx_next_s = S_STOP; else rx_next_s = S_DATA;
            S_STOP:  if (rx_tick_s) rx_next_s = S_IDLE; else rx_next_s = S_STOP;
            default: rx_next_s = S_IDLE;
        endcase
    end

    // RX outputs: timer loads, data sample strobe and FIFO push request.
    always_comb begin
        rx_half_load_s = (rx_state_r == S_IDLE) & (rx_next_s == S_START);
        rx_full_load_s = ((rx_state_r == S_START) & (rx_next_s == S_DATA)) |
                         ((rx_state_r == S_DATA) & rx_tick_s);
        rx_sample_s    = (rx_state_r == S_DATA) & rx_tick_s;
        rx_push_req_s  = (rx_state_r == S_STOP) & rx_tick_s;
    end

    // RX datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_cnt_r <= 9'd0;
            rx_bit_r <= 3'd0;
            rx_sh_r  <= 8'd0;
        end else begin
            if (rx_half_load_s)         rx_cnt_r <= half_m1_s;
            else if (rx_full_load_s)    rx_cnt_r <= bit_len_m1_s;
            else if (rx_cnt_r != 9'd0)  rx_cnt_r <= rx_cnt_r - 9'd1;
            if (rx_half_load_s)         rx_bit_r <= 3'd0;
            else if (rx_sample_s)       rx_bit_r <= rx_bit_r + 3'd1;
            if (rx_sample_s)            rx_sh_r  <= {rx_s2_r, rx_sh_r[7:1]};
        end
    end

    // Register read mux; reading DATA with an empty RX FIFO returns zero.
    always_comb begin
        rd_data_s = 8'h00;
        case (off_s[1:0])
            2'd0:    if (rx_empty_s) rd_data_s = 8'h00; else rd_data_s = rx_head_s;
            2'd1:    rd_data_s = {ferr_r, rxovf_r, txovf_r, (tx_state_r != S_IDLE),
                                  rx_full_s, ~rx_empty_s, tx_full_s, tx_empty_s};
            2'd2:    rd_data_s = div_r;
            2'd3:    rd_data_s = {5'b00000, ctrl_r};
            default: rd_data_s = 8'h00;
        endcase
    end

    assign DI    = rd_act_s ? rd_data_s : 8'hzz;
    assign txd   = txd_r;
    assign irq_n = irq_r;

endmodule

// File: tb/tb_env_console.sv
// Directed self-checking bench for env_console: registers, TX framing, loopback/irq,
// overflow, glitch/framing error, asynchronous reset and long write strobes.
module tb_env_console;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd     = 1'b1;
    wire  [7:0] DI;
    wire        txd;
    wire        irq_n;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rdat;
    logic [9:0] frame;
    int         cyc;

    env_console_if bus_if ();

    env_console #(.BASE_ADDR(8'hA0), .FIFO_AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .DI      (DI),
        .rxd     (rxd),
        .txd     (txd),
        .irq_n   (irq_n)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        bus_if.addr   = a;
        bus_if.DO     = d;
        bus_if.iorq_n = 1'b0;
        bus_if.wr_n   = 1'b0;
        repeat (hold) @(negedge clk);
        bus_if.iorq_n = 1'b1;
        bus_if.wr_n   = 1'b1;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.addr   = a;
        bus_if.iorq_n = 1'b0;
        bus_if.rd_n   = 1'b0;
        #1 d = DI;
        @(negedge clk);
        bus_if.iorq_n = 1'b1;
        bus_if.rd_n   = 1'b1;
        @(negedge clk);
    endtask

    task automatic expect_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        io_read(a, v);
        check_val(tag, {8'h00, v}, {8'h00, exp});
    endtask

    initial begin
        bus_if.iorq_n = 1'b1;
        bus_if.rd_n   = 1'b1;
        bus_if.wr_n   = 1'b1;
        bus_if.addr   = 8'h00;
        bus_if.DO     = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check_val("reset_txd", {15'd0, txd}, 16'd1);
        check_val("reset_irq", {15'd0, irq_n}, 16'd1);
        expect_reg("reset_status", 8'hA1, 8'h01);
        expect_reg("reset_div", 8'hA2, 8'h03);
        expect_reg("reset_ctrl", 8'hA3, 8'h02);

        // Register read-back, unused CTRL bits read zero
        io_write(8'hA3, 8'hFF, 1);
        expect_reg("ctrl_mask", 8'hA3, 8'h07);
        io_write(8'hA3, 8'h02, 1);
        io_write(8'hA2, 8'h05, 1);
        expect_reg("div_rw", 8'hA2, 8'h05);
        io_write(8'hA2, 8'h03, 1);

        // TX frame of 0xA5 at 4 clocks per bit
        frame = {1'b1, 8'hA5, 1'b0};
        io_write(8'hA0, 8'hA5, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_val("txd_frame", {15'd0, txd}, {15'd0, frame[i / 4]});
        end
        expect_reg("tx_done_status", 8'hA1, 8'h01);
        check_val("txd_idle", {15'd0, txd}, 16'd1);

        // Loopback with RX interrupt
        io_write(8'hA3, 8'h07, 1);
        io_write(8'hA0, 8'h3C, 1);
        io_write(8'hA0, 8'hC3, 1);
        cyc = 0;
        while (irq_n && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_val("irq_after_frame1", {15'd0, irq_n}, 16'd0);
        check_val("irq_latency_window", {15'd0, (cyc >= 38 && cyc <= 44)}, 16'd1);
        repeat (50) @(negedge clk);
        expect_reg("lb_status", 8'hA1, 8'h05);
        io_read(8'hA0, rdat);
        check_val("lb_byte1", {8'h00, rdat}, 16'h003C);
        check_val("irq_hold_one_left", {15'd0, irq_n}, 16'd0);
        io_read(8'hA0, rdat);
        check_val("lb_byte2", {8'h00, rdat}, 16'h00C3);
        @(negedge clk);
        check_val("irq_release", {15'd0, irq_n}, 16'd1);
        io_read(8'hA0, rdat);
        check_val("lb_empty_read", {8'h00, rdat}, 16'h0000);
        expect_reg("lb_final_status", 8'hA1, 8'h01);

        // TX overflow and W1C
        io_write(8'hA3, 8'h00, 1);
        for (int k = 0; k < 17; k++) io_write(8'hA0, 8'(k), 1);
        expect_reg("ovf_status", 8'hA1, 8'h22);
        io_write(8'hA1, 8'h20, 1);
        expect_reg("ovf_cleared", 8'hA1, 8'h02);

        // Asynchronous reset in the middle of a frame
        io_write(8'hA3, 8'h02, 1);
        cyc = 0;
        while (txd && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("txd_start_before_reset", {15'd0, txd}, 16'd0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_val("txd_async_reset", {15'd0, txd}, 16'd1);
        @(negedge clk);
        reset_n = 1'b1;
        check_val("irq_after_reset", {15'd0, irq_n}, 16'd1);
        expect_reg("status_after_reset", 8'hA1, 8'h01);
        expect_reg("div_after_reset", 8'hA2, 8'h03);
        expect_reg("ctrl_after_reset", 8'hA3, 8'h02);

        // One-clock glitch on rxd is rejected
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        expect_reg("glitch_status", 8'hA1, 8'h01);

        // Frame with a zero stop bit: byte kept, FERR set
        frame = {1'b0, 8'h5A, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (4) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (12) @(negedge clk);
        expect_reg("ferr_status", 8'hA1, 8'h85);
        check_val("irq_disabled", {15'd0, irq_n}, 16'd1);
        io_read(8'hA0, rdat);
        check_val("ferr_byte", {8'h00, rdat}, 16'h005A);
        io_write(8'hA1, 8'h80, 1);
        expect_reg("ferr_cleared", 8'hA1, 8'h01);

        // Long write strobe adds exactly one entry: 1 + 15 fills, no overflow
        io_write(8'hA3, 8'h00, 1);
        io_write(8'hA0, 8'h11, 5);
        expect_reg("long_strobe_one", 8'hA1, 8'h00);
        for (int k = 0; k < 15; k++) io_write(8'hA0, 8'(k), 1);
        expect_reg("long_strobe_full", 8'hA1, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
